// File: rtl/riscv_id_stage_pkg.sv
// Shared definitions for the RV32I decode stage: XLEN, opcode constants, the NOP encoding
// and immediate-format classification.
`ifndef XLEN
`define XLEN 32
`endif

package riscv_id_stage_pkg;

    localparam int XLEN = `XLEN;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    function automatic imm_type_e imm_type(input logic [6:0] opc);
        case (opc)
            OPC_OPIMM, OPC_LOAD, OPC_JALR: imm_type = IMM_I;
            OPC_STORE:                     imm_type = IMM_S;
            OPC_BRANCH:                    imm_type = IMM_B;
            OPC_LUI, OPC_AUIPC:            imm_type = IMM_U;
            OPC_JAL:                       imm_type = IMM_J;
            default:                       imm_type = IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/riscv_id_stage_if.sv
// Fetch/write-back inputs and decode outputs of the ID stage; master drives the stage, slave is the stage.
interface riscv_id_stage_if;
    import riscv_id_stage_pkg::*;

    logic            i_StallD;
    logic            i_FlushD;
    logic [31:0]     i_IF_instr;
    logic [XLEN-1:0] i_IF_pc_data;
    logic [XLEN-1:0] i_IF_pc_plus_4_data;
    logic            i_WB_reg_write;
    logic [4:0]      i_WB_rd_addr;
    logic [XLEN-1:0] i_WB_rd_data;

    logic [31:0]     o_ID_instr;
    logic [XLEN-1:0] o_ID_rs1_data;
    logic [XLEN-1:0] o_ID_rs2_data;
    logic [XLEN-1:0] o_ID_pc_data;
    logic [XLEN-1:0] o_ID_pc_plus_4_data;
    logic [4:0]      o_ID_rs1_addr;
    logic [4:0]      o_ID_rs2_addr;
    logic [4:0]      o_ID_rd_addr;
    logic [XLEN-1:0] o_ID_imm;

    modport master (
        output i_StallD, i_FlushD, i_IF_instr, i_IF_pc_data, i_IF_pc_plus_4_data,
               i_WB_reg_write, i_WB_rd_addr, i_WB_rd_data,
        input  o_ID_instr, o_ID_rs1_data, o_ID_rs2_data, o_ID_pc_data, o_ID_pc_plus_4_data,
               o_ID_rs1_addr, o_ID_rs2_addr, o_ID_rd_addr, o_ID_imm
    );

    modport slave (
        input  i_StallD, i_FlushD, i_IF_instr, i_IF_pc_data, i_IF_pc_plus_4_data,
               i_WB_reg_write, i_WB_rd_addr, i_WB_rd_data,
        output o_ID_instr, o_ID_rs1_data, o_ID_rs2_data, o_ID_pc_data, o_ID_pc_plus_4_data,
               o_ID_rs1_addr, o_ID_rs2_addr, o_ID_rd_addr, o_ID_imm
    );
endinterface

// File: rtl/riscv_id_stage_regfile.sv
// 31 x XLEN integer register file with hardwired x0 and two combinational read ports.
// Optional WB write-through on the read ports when RISCV_RF_BYPASS_EN is defined.
module riscv_id_stage_regfile
    import riscv_id_stage_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            we_s,
    input  logic [4:0]      waddr_s,
    input  logic [XLEN-1:0] wdata_s,
    input  logic [4:0]      raddr1_s,
    input  logic [4:0]      raddr2_s,
    output logic [XLEN-1:0] rdata1_s,
    output logic [XLEN-1:0] rdata2_s
);

    logic [XLEN-1:0] mem_r [1:31];

    function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr, input logic [XLEN-1:0] stored);
        logic [XLEN-1:0] val;
        if (addr == 5'd0) begin
            val = '0;
        end else begin
`ifdef RISCV_RF_BYPASS_EN
            if (we_s && (waddr_s == addr)) begin
                val = wdata_s;
            end else begin
                val = stored;
            end
`else
            val = stored;
`endif
        end
        return val;
    endfunction

    // Storage: async clear on reset, x0 writes dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 1; k < 32; k++) begin
                mem_r[k] <= '0;
            end
        end else if (we_s && (waddr_s != 5'd0)) begin
            mem_r[waddr_s] <= wdata_s;
        end else begin
            mem_r[1] <= mem_r[1];
        end
    end

    // Read ports.
    always_comb begin
        rdata1_s = '0;
        rdata2_s = '0;
        if (raddr1_s != 5'd0) begin
            rdata1_s = read_port(raddr1_s, mem_r[raddr1_s]);
        end else begin
            rdata1_s = '0;
        end
        if (raddr2_s != 5'd0) begin
            rdata2_s = read_port(raddr2_s, mem_r[raddr2_s]);
        end else begin
            rdata2_s = '0;
        end
    end

endmodule

// File: rtl/riscv_id_stage.sv
// RV32I instruction-decode stage: IF/ID register, register file and inline immediate generator.
// Build option RISCV_RF_BYPASS_EN enables same-cycle WB write-through on register reads.
module riscv_id_stage
    import riscv_id_stage_pkg::*;
#(
    parameter logic [31:0] P_NOP = NOP_INSTR
) (
    input logic         i_clk,
    input logic         i_rst,
    riscv_id_stage_if.slave id_bus
);

    logic [31:0]     instr_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc4_r;
    logic [XLEN-1:0] imm_s;

    // IF/ID register: flush beats stall, both yield to reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            instr_r <= P_NOP;
            pc_r    <= '0;
            pc4_r   <= '0;
        end else if (id_bus.i_FlushD) begin
            instr_r <= P_NOP;
            pc_r    <= '0;
            pc4_r   <= '0;
        end else if (!id_bus.i_StallD) begin
            instr_r <= id_bus.i_IF_instr;
            pc_r    <= id_bus.i_IF_pc_data;
            pc4_r   <= id_bus.i_IF_pc_plus_4_data;
        end else begin
            instr_r <= instr_r;
            pc_r    <= pc_r;
            pc4_r   <= pc4_r;
        end
    end

    // Immediate generator on the registered instruction.
    always_comb begin
        imm_s = '0;
        case (imm_type(instr_r[6:0]))
            IMM_I:   imm_s = {{20{instr_r[31]}}, instr_r[31:20]};
            IMM_S:   imm_s = {{20{instr_r[31]}}, instr_r[31:25], instr_r[11:7]};
            IMM_B:   imm_s = {{19{instr_r[31]}}, instr_r[31], instr_r[7], instr_r[30:25], instr_r[11:8], 1'b0};
            IMM_U:   imm_s = {instr_r[31:12], 12'h000};
            IMM_J:   imm_s = {{11{instr_r[31]}}, instr_r[31], instr_r[19:12], instr_r[20], instr_r[30:21], 1'b0};
            default: imm_s = '0;
        endcase
    end

    riscv_id_stage_regfile u_regfile (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .we_s     (id_bus.i_WB_reg_write),
        .waddr_s  (id_bus.i_WB_rd_addr),
        .wdata_s  (id_bus.i_WB_rd_data),
        .raddr1_s (instr_r[19:15]),
        .raddr2_s (instr_r[24:20]),
        .rdata1_s (id_bus.o_ID_rs1_data),
        .rdata2_s (id_bus.o_ID_rs2_data)
    );

    assign id_bus.o_ID_instr          = instr_r;
    assign id_bus.o_ID_pc_data        = pc_r;
    assign id_bus.o_ID_pc_plus_4_data = pc4_r;
    assign id_bus.o_ID_rs1_addr       = instr_r[19:15];
    assign id_bus.o_ID_rs2_addr       = instr_r[24:20];
    assign id_bus.o_ID_rd_addr        = instr_r[11:7];
    assign id_bus.o_ID_imm            = imm_s;

endmodule
